// File: rtl/wb_mem_responder.sv
// ---------------------------------------------------------------------------
// wb_mem_responder
//
// Pipelined Wishbone B4 slave memory used as the far end of the instruction
// fetch bus. It answers reads with a fixed latency, accepts writes so that
// program contents can be preloaded or patched, and can optionally insert
// pseudo-random stalls to stress the master's handshake logic.
//
// Ports
//   clk_i       : clock, all logic on the rising edge
//   rstn_i      : synchronous active-low reset
//   wb_cyc_i    : bus cycle active; dropping it aborts everything in flight
//   wb_stb_i    : request strobe
//   wb_stall_o  : request not accepted this cycle
//   wb_addr_i   : word address (only the low ADDR_BITS bits are used)
//   wb_we_i     : 1 = write, 0 = read
//   wb_dat_i    : write data
//   wb_ack_o    : response valid
//   wb_data_o   : read data, 0 on write acks and whenever ack is low
// ---------------------------------------------------------------------------
module wb_mem_responder #(
   parameter int          ADDR_BITS  = 8,
   parameter int          LATENCY    = 1,
   parameter int          STALL_MODE = 0,
   parameter int          STALL_MAX  = 3,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter string       INIT_FILE  = ""
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic        wb_stall_o,
   input  logic [15:0] wb_addr_i,
   input  logic        wb_we_i,
   input  logic [15:0] wb_dat_i,
   output logic        wb_ack_o,
   output logic [15:0] wb_data_o
);

   localparam int DEPTH = 1 << ADDR_BITS;

   // ------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------------
   if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
      $error("wb_mem_responder: LATENCY must be within 1..8");
   end
   if (STALL_MODE != 0 && STALL_MODE != 1) begin : g_bad_stall_mode
      $error("wb_mem_responder: STALL_MODE must be 0 or 1");
   end
   if (STALL_MAX < 1 || STALL_MAX > 15) begin : g_bad_stall_max
      $error("wb_mem_responder: STALL_MAX must be within 1..15");
   end
   if (LFSR_SEED == 16'h0000) begin : g_bad_seed
      $error("wb_mem_responder: LFSR_SEED must be nonzero");
   end
   if (ADDR_BITS < 1 || ADDR_BITS > 16) begin : g_bad_addr_bits
      $error("wb_mem_responder: ADDR_BITS must be within 1..16");
   end

   // ------------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------------
   logic [15:0]          mem_q [DEPTH];

   logic [LATENCY-1:0]   vld_q, vld_d;
   logic [15:0]          dat_q [LATENCY];
   logic [15:0]          dat_d [LATENCY];
   logic [15:0]          lfsr_q, lfsr_d;
   logic [3:0]           scnt_q, scnt_d;

   logic                 accept;
   logic                 stall;
   logic [ADDR_BITS-1:0] idx;
   logic [15:0]          rdata;
   logic                 lfsr_fb;

   // Upper address bits are deliberately ignored (implicit wrap-around).
   if (ADDR_BITS < 16) begin : g_addr_unused
      logic unused_addr_hi;
      assign unused_addr_hi = ^wb_addr_i[15:ADDR_BITS];
   end

   assign idx   = wb_addr_i[ADDR_BITS-1:0];
   assign rdata = mem_q[idx];

   // ------------------------------------------------------------------------
   // Stall generation
   // Fibonacci LFSR, taps 16,14,13,11, shifting right; bit 0 is the output.
   // The run counter caps consecutive stalls at STALL_MAX so the master is
   // always guaranteed forward progress.
   // ------------------------------------------------------------------------
   assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
   assign lfsr_d  = {lfsr_fb, lfsr_q[15:1]};

   assign stall = (STALL_MODE == 1) && lfsr_q[0] &&
                  (scnt_q < 4'(STALL_MAX)) && rstn_i;

   assign scnt_d = stall ? (scnt_q + 4'd1) : 4'd0;

   assign wb_stall_o = stall;

   // Requests arriving while reset is held are ignored.
   assign accept = wb_cyc_i && wb_stb_i && !stall && rstn_i;

   // ------------------------------------------------------------------------
   // Response pipeline: never back-pressured, shifts every cycle. Dropping
   // cyc clears every valid bit so aborted requests are never acked.
   // ------------------------------------------------------------------------
   always_comb begin
      vld_d    = '0;
      dat_d[0] = (accept && !wb_we_i) ? rdata : 16'h0000;
      for (int i = 1; i < LATENCY; i++) begin
         dat_d[i] = dat_q[i-1];
      end
      if (wb_cyc_i) begin
         vld_d[0] = accept;
         for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         vld_q  <= '0;
         lfsr_q <= LFSR_SEED;
         scnt_q <= 4'd0;
         for (int i = 0; i < LATENCY; i++) begin
            dat_q[i] <= 16'h0000;
         end
      end else begin
         vld_q  <= vld_d;
         lfsr_q <= lfsr_d;
         scnt_q <= scnt_d;
         for (int i = 0; i < LATENCY; i++) begin
            dat_q[i] <= dat_d[i];
         end
      end
   end

   // Memory contents survive reset. Read data for the same edge is taken
   // from the pre-write value above, so in-flight reads are never disturbed.
   always_ff @(posedge clk_i) begin
      if (accept && wb_we_i) begin
         mem_q[idx] <= wb_dat_i;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: ack is qualified by cyc and held low while reset is asserted.
   // ------------------------------------------------------------------------
   assign wb_ack_o  = vld_q[LATENCY-1] && wb_cyc_i && rstn_i;
   assign wb_data_o = wb_ack_o ? dat_q[LATENCY-1] : 16'h0000;

endmodule

// File: tb/tb_wb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_wb_mem_responder
//
// Five responders share one bus stimulus: latencies 1..4 without stalls and
// latency 3 with LFSR stalls (STALL_MAX=3). A reference model per instance
// tracks memory, LFSR and stall run length, pushes expected responses into
// a scoreboard queue at each accept and pops/compares them at the due cycle.
// ---------------------------------------------------------------------------
module tb_wb_mem_responder;

   localparam int NI = 5;

   typedef struct {
      int          due;
      logic [15:0] d;
   } exp_t;

   logic        clk  = 1'b0;
   logic        rstn = 1'b0;
   logic        cyc  = 1'b0;
   logic        stb  = 1'b0;
   logic        we   = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic [15:0] dat  = 16'h0000;

   logic        stall_w [NI];
   logic        ack_w   [NI];
   logic [15:0] rdat_w  [NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      wb_mem_responder #(
         .ADDR_BITS  (8),
         .LATENCY    ((g < 4) ? g + 1 : 3),
         .STALL_MODE ((g == 4) ? 1 : 0),
         .STALL_MAX  (3),
         .LFSR_SEED  (16'hACE1),
         .INIT_FILE  ("")
      ) u_dut (
         .clk_i      (clk),
         .rstn_i     (rstn),
         .wb_cyc_i   (cyc),
         .wb_stb_i   (stb),
         .wb_stall_o (stall_w[g]),
         .wb_addr_i  (addr),
         .wb_we_i    (we),
         .wb_dat_i   (dat),
         .wb_ack_o   (ack_w[g]),
         .wb_data_o  (rdat_w[g])
      );
   end

   function automatic int lat_of(int g);
      return (g < 4) ? g + 1 : 3;
   endfunction

   // ------------------------------------------------------------------------
   // Reference model (updated on the rising edge)
   // ------------------------------------------------------------------------
   int          ecnt = 0;
   logic [15:0] lfsr_m [NI];
   int          cnt_m  [NI];
   logic [15:0] mm     [NI][256];
   exp_t        sb     [NI][$];
   int          run4   = 0;
   int          n_pass = 0;
   int          n_fail = 0;

   always @(posedge clk) begin
      ecnt = ecnt + 1;
      for (int g = 0; g < NI; g++) begin
         logic       st;
         logic [7:0] ix;
         exp_t       e;
         if (!rstn) begin
            sb[g].delete();
            lfsr_m[g] = 16'hACE1;
            cnt_m[g]  = 0;
         end else begin
            st = (g == 4) && lfsr_m[g][0] && (cnt_m[g] < 3);
            if (!cyc) sb[g].delete();
            if (cyc && stb && !st) begin
               ix    = addr[7:0];
               e.due = ecnt + lat_of(g) - 1;
               e.d   = we ? 16'h0000 : mm[g][ix];
               sb[g].push_back(e);
               if (we) mm[g][ix] = dat;
            end
            cnt_m[g]  = st ? cnt_m[g] + 1 : 0;
            lfsr_m[g] = {lfsr_m[g][0] ^ lfsr_m[g][2] ^ lfsr_m[g][3] ^ lfsr_m[g][5],
                         lfsr_m[g][15:1]};
         end
      end
   end

   // ------------------------------------------------------------------------
   // Checker (falling edge, away from the active edge)
   // ------------------------------------------------------------------------
   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         logic        e_st;
         logic        e_ack;
         logic [15:0] e_dat;
         e_st  = (g == 4) && rstn && lfsr_m[g][0] && (cnt_m[g] < 3);
         e_ack = 1'b0;
         e_dat = 16'h0000;
         if (sb[g].size() > 0 && sb[g][0].due == ecnt) begin
            if (cyc && rstn) begin
               e_ack = 1'b1;
               e_dat = sb[g][0].d;
            end
            void'(sb[g].pop_front());
         end
         assert (stall_w[g] === e_st) n_pass++;
         else begin
            n_fail++;
            $error("FAIL stall[%0d] edge %0d: got %b expected %b", g, ecnt, stall_w[g], e_st);
         end
         assert (ack_w[g] === e_ack) n_pass++;
         else begin
            n_fail++;
            $error("FAIL ack[%0d] edge %0d: got %b expected %b", g, ecnt, ack_w[g], e_ack);
         end
         assert (rdat_w[g] === e_dat) n_pass++;
         else begin
            n_fail++;
            $error("FAIL data[%0d] edge %0d: got %h expected %h", g, ecnt, rdat_w[g], e_dat);
         end
      end
      if (stall_w[4] === 1'b1) run4++;
      else run4 = 0;
      assert (run4 <= 3) n_pass++;
      else begin
         n_fail++;
         $error("FAIL stall_run edge %0d: got %0d expected <= 3", ecnt, run4);
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   task automatic drv(input logic c, input logic s, input logic w,
                      input logic [15:0] a, input logic [15:0] d);
      @(posedge clk);
      #1;
      cyc  = c;
      stb  = s;
      we   = w;
      addr = a;
      dat  = d;
   endtask

   task automatic idle(input int n);
      repeat (n) drv(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;

      // preload
      drv(1'b1, 1'b1, 1'b1, 16'h0005, 16'h1234);
      for (int i = 0; i < 4; i++) drv(1'b1, 1'b1, 1'b1, 16'(i), 16'(16'h0100 + i));
      idle(6);

      // single read
      drv(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000);
      idle(6);

      // back-to-back reads
      for (int i = 0; i < 4; i++) drv(1'b1, 1'b1, 1'b0, 16'(i), 16'h0000);
      idle(6);

      // write then read-after-write, plus wrapped alias
      drv(1'b1, 1'b1, 1'b1, 16'h0007, 16'hBEEF);
      drv(1'b1, 1'b1, 1'b0, 16'h0007, 16'h0000);
      drv(1'b1, 1'b1, 1'b0, 16'h0107, 16'h0000);
      idle(6);

      // abort: two reads, drop cyc for one cycle, then a fresh read
      drv(1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
      drv(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0000);
      drv(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      drv(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000);
      idle(6);

      // stall stress: stb held high for 200 cycles
      for (int i = 0; i < 200; i++) begin
         logic        w;
         logic [15:0] a;
         w = ($urandom_range(0, 7) == 0);
         a = 16'($urandom_range(0, 7)) | (($urandom_range(0, 1) == 1) ? 16'h0100 : 16'h0000);
         drv(1'b1, 1'b1, w, a, 16'($urandom));
      end
      idle(6);

      // reset while two reads are in flight
      drv(1'b1, 1'b1, 1'b0, 16'h0001, 16'h0000);
      drv(1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      stb  = 1'b0;
      @(posedge clk);
      #1 rstn = 1'b1;
      idle(12);
      drv(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000);
      idle(6);
      drv(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (3) @(posedge clk);

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
      $finish;
   end

endmodule
